// File: rtl/ksneq32_rkrev.sv
// Round-key reversal buffer: captures the forward key-schedule stream into a LIFO
// and replays it last-first over a valid/ready handshake for the decryption rounds.
module ksneq32_rkrev #(
   parameter int CWIDTH = 192,
   parameter int XWIDTH = 64,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        kWidth,
   input  logic [CWIDTH-1:0] cin,
   input  logic [XWIDTH-1:0] xin,
   input  logic              inValid,
   input  logic              start,
   input  logic              rdReady,
   output logic [CWIDTH-1:0] cout,
   output logic [XWIDTH-1:0] xout,
   output logic              outValid,
   output logic              full,
   output logic              done,
   output logic              err
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, FULL, DRAIN, DONE} stateT;

   stateT            state;
   stateT            nextState;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW-1:0]    nReg;
   logic [PW-1:0]    nSel;
   logic [PW-1:0]    wptrInc;
   logic [PW-1:0]    lastIdx;
   logic [PW-1:0]    rptrDec;
   logic             writeEn;
   logic             pop;
   logic             badStart;

   logic [CWIDTH-1:0] memC [DEPTH];
   logic [XWIDTH-1:0] memX [DEPTH];

   assign wptrInc = wptr + PW'(1);
   assign lastIdx = nReg - PW'(1);
   assign rptrDec = rptr - PW'(1);

   // Entry count is only latched on the first accepted write, so later kWidth changes are harmless
   always_comb begin
      nSel = PW'(11);
      case (kWidth)
         2'b00:   nSel = PW'(11);
         2'b01:   nSel = PW'(13);
         2'b10:   nSel = PW'(15);
         default: nSel = PW'(11);
      endcase
   end

   always_comb begin
      nextState = state;
      writeEn   = 1'b0;
      pop       = 1'b0;
      badStart  = 1'b0;
      case (state)
         IDLE: begin
            if (inValid && !err) begin
               if (kWidth == 2'b11) begin
                  badStart = 1'b1;
               end else begin
                  writeEn   = 1'b1;
                  nextState = LOAD;
               end
            end
         end
         LOAD: begin
            if (inValid) begin
               writeEn = 1'b1;
               if (wptrInc == nReg) nextState = FULL;
            end
         end
         FULL: begin
            if (start) nextState = DRAIN;
         end
         DRAIN: begin
            if (outValid && rdReady) begin
               pop = 1'b1;
               if (rptr == '0) nextState = DONE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Key storage is deliberately left out of reset; only the pointers define what is live
   always_ff @(posedge clk) begin
      if (writeEn) begin
         memC[wptr] <= cin;
         memX[wptr] <= xin;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wptr     <= '0;
         rptr     <= '0;
         nReg     <= '0;
         cout     <= '0;
         xout     <= '0;
         outValid <= 1'b0;
         full     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= nextState;
         done  <= 1'b0;
         if (badStart) err <= 1'b1;
         if (writeEn) begin
            wptr <= wptrInc;
            if (state == IDLE) nReg <= nSel;
         end
         if (state == LOAD && nextState == FULL) full <= 1'b1;
         if (state == FULL && start) begin
            full     <= 1'b0;
            rptr     <= lastIdx;
            cout     <= memC[lastIdx];
            xout     <= memX[lastIdx];
            outValid <= 1'b1;
         end
         // The next entry is fetched on the pop itself so outputs stay registered
         if (pop) begin
            if (rptr == '0) begin
               outValid <= 1'b0;
               done     <= 1'b1;
            end else begin
               rptr <= rptrDec;
               cout <= memC[rptrDec];
               xout <= memX[rptrDec];
            end
         end
         if (state == DONE) begin
            wptr <= '0;
            rptr <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ksneq32_rkrev.sv
// Directed self-checking bench for the round-key reversal buffer.
module tb_ksneq32_rkrev;

   localparam int CW = 192;
   localparam int XW = 64;

   logic          clk;
   logic          reset;
   logic [1:0]    kWidth;
   logic [CW-1:0] cin;
   logic [XW-1:0] xin;
   logic          inValid;
   logic          start;
   logic          rdReady;
   logic [CW-1:0] cout;
   logic [XW-1:0] xout;
   logic          outValid;
   logic          full;
   logic          done;
   logic          err;

   int testsRun;
   int testsFailed;

   ksneq32_rkrev #(.CWIDTH(CW), .XWIDTH(XW), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .kWidth(kWidth), .cin(cin), .xin(xin),
      .inValid(inValid), .start(start), .rdReady(rdReady), .cout(cout),
      .xout(xout), .outValid(outValid), .full(full), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      reset   = 1'b1;
      inValid = 1'b0;
      start   = 1'b0;
      rdReady = 1'b0;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] kw, input int first, input int count, input int base);
      for (int i = first; i < first + count; i++) begin
         kWidth  = kw;
         cin     = CW'(i + base);
         xin     = XW'(i + base);
         inValid = 1'b1;
         step();
      end
      inValid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      kWidth = 2'b00; cin = '0; xin = '0;
      inValid = 1'b0; start = 1'b0; rdReady = 1'b0;
      step();
      testsRun++;
      if (cout !== '0 || xout !== '0 || outValid !== 1'b0 || full !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_state: got cout=%0h xout=%0h ov=%b full=%b done=%b err=%b, want all 0",
                  cout, xout, outValid, full, done, err);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      applyReset();
      applyStimulus(2'b00, 0, 10, 0);
      testsRun++;
      if (full !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL basic_full_early: got %b want 0", full);
      end
      applyStimulus(2'b00, 10, 1, 0);
      testsRun++;
      if (full !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL basic_full: got %b want 1", full);
      end
      rdReady = 1'b1;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 10; k >= 0; k--) begin
         testsRun++;
         if (outValid !== 1'b1 || cout !== CW'(k) || xout !== XW'(k) || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_drain: got ov=%b cout=%0d xout=%0d done=%b want ov=1 %0d done=0",
                     outValid, cout, xout, done, k);
         end
         step();
      end
      testsRun++;
      if (done !== 1'b1 || outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL basic_done: got done=%b ov=%b want done=1 ov=0", done, outValid);
      end
      step();
      testsRun++;
      if (done !== 1'b0 || outValid !== 1'b0 || full !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL basic_idle: got done=%b ov=%b full=%b want 0 0 0", done, outValid, full);
      end
      rdReady = 1'b0;
   endtask

   task automatic test_toggle();
      int expected;
      int cycle;
      logic [CW-1:0] held;
      applyReset();
      applyStimulus(2'b10, 0, 15, 0);
      testsRun++;
      if (full !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL toggle_full: got %b want 1", full);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      expected = 14;
      cycle = 0;
      while (expected >= 0 && cycle < 100) begin
         rdReady = (cycle % 3 == 0);
         testsRun++;
         if (outValid !== 1'b1 || cout !== CW'(expected) || xout !== XW'(expected)) begin
            testsFailed++;
            $display("[TB] FAIL toggle_value: got ov=%b cout=%0d xout=%0d want ov=1 %0d", outValid, cout, xout, expected);
         end
         held = cout;
         step();
         if (rdReady) begin
            expected--;
         end else begin
            testsRun++;
            if (cout !== held) begin
               testsFailed++;
               $display("[TB] FAIL toggle_hold: got %0d want %0d", cout, held);
            end
         end
         cycle++;
      end
      testsRun++;
      if (expected >= 0 || done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL toggle_done: got done=%b remaining=%0d want done=1 remaining=-1", done, expected);
      end
      rdReady = 1'b0;
      step();
   endtask

   task automatic test_illegal();
      applyReset();
      applyStimulus(2'b11, 0, 3, 0);
      testsRun++;
      if (err !== 1'b1 || full !== 1'b0 || outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL illegal_err: got err=%b full=%b ov=%b want 1 0 0", err, full, outValid);
      end
      applyStimulus(2'b00, 0, 11, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      testsRun++;
      if (err !== 1'b1 || full !== 1'b0 || outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL illegal_sticky: got err=%b full=%b ov=%b want 1 0 0", err, full, outValid);
      end
      applyReset();
      testsRun++;
      if (err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL illegal_clear: got err=%b want 0", err);
      end
   endtask

   task automatic test_extra();
      applyReset();
      applyStimulus(2'b01, 0, 13, 0);
      for (int i = 0; i < 3; i++) begin
         kWidth = 2'b00; cin = '1; xin = '1; inValid = 1'b1;
         step();
      end
      inValid = 1'b0;
      testsRun++;
      if (full !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL extra_full: got %b want 1", full);
      end
      rdReady = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 12; k >= 0; k--) begin
         testsRun++;
         if (outValid !== 1'b1 || cout !== CW'(k) || xout !== XW'(k)) begin
            testsFailed++;
            $display("[TB] FAIL extra_drain: got ov=%b cout=%0h xout=%0h want ov=1 %0h", outValid, cout, xout, k);
         end
         step();
      end
      testsRun++;
      if (done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL extra_done: got %b want 1", done);
      end
      rdReady = 1'b0;
      step();
   endtask

   task automatic test_start_during_load();
      applyReset();
      applyStimulus(2'b00, 0, 5, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      testsRun++;
      if (outValid !== 1'b0 || full !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL early_start: got ov=%b full=%b want 0 0", outValid, full);
      end
      applyStimulus(2'b10, 5, 6, 0);
      testsRun++;
      if (full !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL early_full: got %b want 1", full);
      end
      rdReady = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 10; k >= 0; k--) begin
         testsRun++;
         if (outValid !== 1'b1 || cout !== CW'(k)) begin
            testsFailed++;
            $display("[TB] FAIL early_drain: got ov=%b cout=%0d want ov=1 %0d", outValid, cout, k);
         end
         step();
      end
      rdReady = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_drain();
      applyReset();
      applyStimulus(2'b00, 0, 11, 0);
      rdReady = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      #1;
      testsRun++;
      if (cout !== '0 || xout !== '0 || outValid !== 1'b0 || full !== 1'b0 || done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL middrain_reset: got cout=%0d xout=%0d ov=%b full=%b done=%b want all 0",
                  cout, xout, outValid, full, done);
      end
      step();
      reset = 1'b0;
      rdReady = 1'b0;
      step();
      testsRun++;
      if (done !== 1'b0 || outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL middrain_nodone: got done=%b ov=%b want 0 0", done, outValid);
      end
      applyStimulus(2'b00, 0, 11, 100);
      rdReady = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 10; k >= 0; k--) begin
         testsRun++;
         if (outValid !== 1'b1 || cout !== CW'(k + 100) || xout !== XW'(k + 100)) begin
            testsFailed++;
            $display("[TB] FAIL middrain_reload: got ov=%b cout=%0d want ov=1 %0d", outValid, cout, k + 100);
         end
         step();
      end
      testsRun++;
      if (done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL middrain_done: got %b want 1", done);
      end
      rdReady = 1'b0;
      step();
   endtask

   initial begin
      testsRun = 0;
      testsFailed = 0;
      test_reset();
      test_basic();
      test_toggle();
      test_illegal();
      test_extra();
      test_start_during_load();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ksneq32_rkrev.md
# ksneq32_rkrev

Round-key reversal buffer for the decryption path. It captures the round-key stream produced by the forward key schedule (`ksneq32`: one `{cout, xout}` pair per cycle) into an internal LIFO. On request it replays the stored round keys in reverse order through a valid/ready handshake, so the decryption datapath receives the last encryption round key first. It sits between the forward key-schedule output and the decryption round engine.

## Interface
Parameters:
- `CWIDTH`, 192, width of the C part of each round key
- `XWIDTH`, 64, width of the X part of each round key
- `DEPTH`, 16, LIFO entries; must be ≥ 15

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-high; clears all state
- `kWidth`  in  2  key-size code; selects the expected entry count N
- `cin`  in  CWIDTH  C part of the incoming round key
- `xin`  in  XWIDTH  X part of the incoming round key
- `inValid`  in  1  `cin`/`xin` hold a valid round key this cycle
- `start`  in  1  single-cycle pulse; begins reverse readout
- `rdReady`  in  1  consumer accepts `cout`/`xout` this cycle
- `cout`  out  CWIDTH  C part of the round key being replayed
- `xout`  out  XWIDTH  X part of the round key being replayed
- `outValid`  out  1  `cout`/`xout` are valid
- `full`  out  1  all N entries are loaded
- `done`  out  1  one-cycle pulse after the final entry is popped
- `err`  out  1  sticky error; `kWidth` was 2'b11 at load start

## Operation
- N by `kWidth`, sampled on the first accepted write:
  - 00 → 11
  - 01 → 13
  - 10 → 15
  - 11 → illegal: set `err`, accept no writes, stay IDLE until reset
- States: IDLE, LOAD, FULL, DRAIN, DONE.
- IDLE: on `inValid` (and legal `kWidth`), write entry 0, set wptr=1, go to LOAD.
- LOAD: each `inValid` cycle writes `mem[wptr]` and increments wptr. When wptr reaches N, go to FULL. Writes need not be consecutive.
- FULL: `full`=1. `inValid` is ignored and memory is unchanged. `start` → DRAIN, with rptr=N-1 and entry N-1 registered onto the outputs.
- DRAIN: `outValid`=1. A pop occurs when `outValid && rdReady`. On a pop, present `mem[rptr-1]` in the next cycle. If `rdReady`=0, outputs hold stable.
  - Popping entry 0 → DONE.
- DONE: `done`=1 for exactly one cycle, `outValid`=0, then IDLE with pointers cleared. Stored data is not cleared.
- `start` outside FULL is ignored.
- `inValid` in DRAIN or DONE is ignored.
- `kWidth` changes after the first write have no effect.

## Timing
- Reset values (asynchronous): state=IDLE, wptr=rptr=0, `cout`=0, `xout`=0, `outValid`=0, `full`=0, `done`=0, `err`=0.
- Write: data presented at edge t is stored at edge t; `full` rises the cycle after the Nth write.
- Readout latency: `start` sampled at edge t → `outValid`=1 with entry N-1 after edge t.
- Throughput: one entry per cycle when `rdReady` is held high. N entries drain in N cycles, and `done` is asserted in cycle N+1 after `start`.
- Outputs are registered; no combinational path from `rdReady` to `cout`/`xout`.
- `outValid` falls in the same cycle `done` rises.
- Reset asserted mid-LOAD or mid-DRAIN returns the block to IDLE immediately.
  - No `done` pulse is generated.
  - The next load starts from entry 0.
- `err` clears only on reset.

## Test plan
- kWidth=00; write `cin`=i, `xin`=i for i=0..10 on consecutive cycles; `start`; `rdReady`=1 → `full` after the 11th write; `cout`/`xout` = 10,9,…,0 on 11 consecutive cycles; `done` one cycle later, then IDLE.
- kWidth=10, 15 writes; `rdReady` toggles 1,0,0,1,… → values 14..0 with no loss or duplication; outputs hold while `rdReady`=0.
- kWidth=11 with `inValid` → `err`=1, `full` never asserts, `outValid` stays 0; `reset` clears `err`.
- kWidth=01, 13 writes, then 3 extra `inValid` cycles with `cin`=FF… → extras ignored; readout is 12..0 unchanged.
- `start` pulsed during LOAD (wptr=5) → ignored; completing the load to N then `start` gives normal readout.
- `reset` asserted at the 4th pop of the DRAIN → all outputs 0 immediately, no `done`; a fresh 11-entry load drains correctly as 10..0.
